// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared command codes, keycodes and key-timing FSM states
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_LEFT  = 3'd1,
    CMD_RIGHT = 3'd2,
    CMD_DOWN  = 3'd3,
    CMD_ROT   = 3'd4,
    CMD_DROP  = 3'd5
  } cmd_e;

  localparam logic [15:0] KEY_A     = 16'h0004;
  localparam logic [15:0] KEY_D     = 16'h0007;
  localparam logic [15:0] KEY_S     = 16'h0016;
  localparam logic [15:0] KEY_W     = 16'h001A;
  localparam logic [15:0] KEY_SPACE = 16'h002C;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DAS_WAIT = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_HOLD     = 2'd3
  } key_state_e;

  // State entered when a freshly pressed key has just fired.
  function automatic key_state_e entry_state(cmd_e key);
    case (key)
      CMD_LEFT, CMD_RIGHT: entry_state = ST_DAS_WAIT;
      CMD_DOWN:            entry_state = ST_REPEAT;
      CMD_ROT, CMD_DROP:   entry_state = ST_HOLD;
      default:             entry_state = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/key_cmd_gen_if.sv
// rtl/key_cmd_gen_if.sv - valid/ready command channel from key_cmd_gen to the piece controller
interface key_cmd_gen_if;
  import tetris_pkg::*;

  logic cmd_valid;
  logic cmd_ready;
  cmd_e cmd;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);

endinterface

// File: rtl/key_decode.sv
// rtl/key_decode.sv - combinational raw keycode to command mapping; unknown codes read as no key
module key_decode
  import tetris_pkg::*;
(
  input  logic [15:0] keycode,
  output cmd_e        key_cmd
);

  always_comb begin
    key_cmd = CMD_NONE;
    case (keycode)
      KEY_A:     key_cmd = CMD_LEFT;
      KEY_D:     key_cmd = CMD_RIGHT;
      KEY_S:     key_cmd = CMD_DOWN;
      KEY_W:     key_cmd = CMD_ROT;
      KEY_SPACE: key_cmd = CMD_DROP;
      default:   key_cmd = CMD_NONE;
    endcase
  end

endmodule

// File: rtl/key_cmd_gen.sv
// rtl/key_cmd_gen.sv - held keycode to one-shot move commands with DAS/auto-repeat and a one-deep output register
module key_cmd_gen
  import tetris_pkg::*;
#(
  parameter int DAS_DELAY  = 16,
  parameter int ARR_PERIOD = 6,
  parameter int SD_PERIOD  = 2
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [15:0]          keycode,
  input  logic                 enable,
  key_cmd_gen_if.master        cmd_if,
  output logic                 overrun
);

  localparam logic [7:0] DAS_LAST = 8'(DAS_DELAY - 1);
  localparam logic [7:0] ARR_LAST = 8'(ARR_PERIOD - 1);
  localparam logic [7:0] SD_LAST  = 8'(SD_PERIOD - 1);

  cmd_e       dec_key;
  key_state_e state_q, state_d;
  cmd_e       last_key_q, last_key_d;
  logic [7:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  cmd_e       cmd_q, cmd_d;
  logic       overrun_q, overrun_d;
  logic       fire;
  logic [7:0] period_last;

  key_decode u_decode (
    .keycode (keycode),
    .key_cmd (dec_key)
  );

  assign period_last = (last_key_q == CMD_DOWN) ? SD_LAST : ARR_LAST;

  // Timing FSM: a fired command is always the currently decoded key.
  always_comb begin
    state_d    = state_q;
    last_key_d = dec_key;
    cnt_d      = cnt_q;
    fire       = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
    end else if (dec_key != last_key_q) begin
      fire    = (dec_key != CMD_NONE);
      cnt_d   = 8'd0;
      state_d = entry_state(dec_key);
    end else begin
      case (state_q)
        ST_DAS_WAIT: begin
          if (cnt_q == DAS_LAST) begin
            fire    = 1'b1;
            cnt_d   = 8'd0;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_REPEAT: begin
          if (cnt_q == period_last) begin
            fire  = 1'b1;
            cnt_d = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output register: a fire during a stalled pending command is dropped and flagged.
  always_comb begin
    valid_d   = valid_q;
    cmd_d     = cmd_q;
    overrun_d = 1'b0;
    if (!enable) begin
      valid_d = 1'b0;
      cmd_d   = CMD_NONE;
    end else if (fire) begin
      if (!valid_q || cmd_if.cmd_ready) begin
        valid_d = 1'b1;
        cmd_d   = dec_key;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && cmd_if.cmd_ready) begin
      valid_d = 1'b0;
      cmd_d   = CMD_NONE;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      last_key_q <= CMD_NONE;
      cnt_q      <= 8'd0;
      valid_q    <= 1'b0;
      cmd_q      <= CMD_NONE;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_key_q <= last_key_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      cmd_q      <= cmd_d;
      overrun_q  <= overrun_d;
    end
  end

  assign cmd_if.cmd_valid = valid_q;
  assign cmd_if.cmd       = cmd_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_key_cmd_gen.sv
// tb/tb_key_cmd_gen.sv - directed vector table plus reset sequence for key_cmd_gen
module tb_key_cmd_gen;
  import tetris_pkg::*;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [15:0] keycode;
  logic        enable;
  logic        overrun;

  key_cmd_gen_if bus ();

  key_cmd_gen dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .enable    (enable),
    .cmd_if    (bus),
    .overrun   (overrun)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [15:0] key;
    bit          en;
    bit          rdy;
    bit          exp_valid;
    cmd_e        exp_cmd;
    bit          exp_ovr;
    int          scen;
  } vec_t;

  vec_t vecs[$];
  int   scen   = 0;
  int   checks = 0;
  int   passed = 0;

  function automatic void add(logic [15:0] k, bit en, bit rdy, bit v, cmd_e c, bit o);
    vec_t t;
    t.key = k; t.en = en; t.rdy = rdy; t.exp_valid = v; t.exp_cmd = c; t.exp_ovr = o; t.scen = scen;
    vecs.push_back(t);
  endfunction

  // Hold a key with cmd_ready=1 for n edges; valid is expected exactly on the listed edge offsets.
  function automatic void add_hold(logic [15:0] k, int n, cmd_e c, int f0, int f1, int f2, int f3, int f4);
    for (int i = 0; i < n; i++)
      add(k, 1'b1, 1'b1, (i == f0) || (i == f1) || (i == f2) || (i == f3) || (i == f4), c, 1'b0);
  endfunction

  task automatic chk(string name, int idx, int got, int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s vec %0d: got %0d want %0d", name, idx, got, want);
  endtask

  initial begin
    Reset = 1'b1; keycode = 16'h0; enable = 1'b1; bus.cmd_ready = 1'b1;

    // s0: LEFT held 40 edges, then release
    scen = 0; add_hold(KEY_A, 40, CMD_LEFT, 0, 16, 22, 28, 34);
    add_hold(16'h0000, 2, CMD_NONE, -1, -1, -1, -1, -1);
    // s1: DOWN has no DAS
    scen = 1; add_hold(KEY_S, 7, CMD_DOWN, 0, 2, 4, 6, -1);
    add_hold(16'h0000, 1, CMD_NONE, -1, -1, -1, -1, -1);
    // s2: ROT fires once per press
    scen = 2; add_hold(KEY_W, 20, CMD_ROT, 0, -1, -1, -1, -1);
    add_hold(16'h0000, 3, CMD_NONE, -1, -1, -1, -1, -1);
    add_hold(KEY_W, 5, CMD_ROT, 0, -1, -1, -1, -1);
    add_hold(16'h0000, 1, CMD_NONE, -1, -1, -1, -1, -1);
    // s3: stalled consumer, DAS fire at edge 16 overruns
    scen = 3;
    for (int i = 0; i <= 16; i++) add(KEY_D, 1'b1, 1'b0, 1'b1, CMD_RIGHT, i == 16);
    add(KEY_D, 1'b1, 1'b1, 1'b0, CMD_NONE, 1'b0);
    add(16'h0000, 1'b1, 1'b1, 1'b0, CMD_NONE, 1'b0);
    // s4: direct LEFT->RIGHT switch, then unknown code acts as release
    scen = 4; add_hold(KEY_A, 10, CMD_LEFT, 0, -1, -1, -1, -1);
    add_hold(KEY_D, 21, CMD_RIGHT, 0, 16, -1, -1, -1);
    add_hold(16'h1234, 3, CMD_NONE, -1, -1, -1, -1, -1);
    // s5: enable drop clears pending; held key needs a re-press
    scen = 5;
    add(KEY_A, 1'b1, 1'b0, 1'b1, CMD_LEFT, 1'b0);
    add(KEY_A, 1'b0, 1'b0, 1'b0, CMD_NONE, 1'b0);
    for (int i = 0; i < 18; i++) add(KEY_A, 1'b1, 1'b0, 1'b0, CMD_NONE, 1'b0);
    add(16'h0000, 1'b1, 1'b0, 1'b0, CMD_NONE, 1'b0);
    add(KEY_A, 1'b1, 1'b0, 1'b1, CMD_LEFT, 1'b0);
    add(16'h0000, 1'b1, 1'b1, 1'b0, CMD_NONE, 1'b0);

    @(posedge frame_clk); @(posedge frame_clk); #1;
    chk("reset_valid", -1, bus.cmd_valid, 0);
    chk("reset_cmd", -1, bus.cmd, CMD_NONE);
    chk("reset_overrun", -1, overrun, 0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      keycode = vecs[i].key; enable = vecs[i].en; bus.cmd_ready = vecs[i].rdy;
      @(posedge frame_clk); #1;
      chk($sformatf("s%0d_valid", vecs[i].scen), i, bus.cmd_valid, vecs[i].exp_valid);
      chk($sformatf("s%0d_overrun", vecs[i].scen), i, overrun, vecs[i].exp_ovr);
      if (vecs[i].exp_valid) chk($sformatf("s%0d_cmd", vecs[i].scen), i, bus.cmd, vecs[i].exp_cmd);
    end

    // Reset mid-operation with a pending LEFT, then refire after deassertion
    keycode = KEY_A; enable = 1'b1; bus.cmd_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge frame_clk); #1;
      chk("rst_pre_valid", i, bus.cmd_valid, 1);
    end
    chk("rst_pre_cmd", 0, bus.cmd, CMD_LEFT);
    #2 Reset = 1'b1;
    #1;
    chk("rst_async_valid", 0, bus.cmd_valid, 0);
    chk("rst_async_cmd", 0, bus.cmd, CMD_NONE);
    chk("rst_async_overrun", 0, overrun, 0);
    @(negedge frame_clk); @(negedge frame_clk);
    Reset = 1'b0;
    @(posedge frame_clk); #1;
    chk("rst_refire_valid", 0, bus.cmd_valid, 1);
    chk("rst_refire_cmd", 0, bus.cmd, CMD_LEFT);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
